// File: rtl/fmap_ram_pkg.sv
// Shared types for the feature-map RAM port arbiter.
// Round-robin arbitration is selected with FMAP_ARB_RR_EN.
package fmap_ram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic REQ_LOAD = 1'b0;
   localparam logic REQ_CONV = 1'b1;

   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fmap_arb_pick.sv
// Winner select for a fresh burst when the arbiter is idle.
// FMAP_ARB_RR_EN: round-robin; otherwise requester 0 has priority.
module fmap_arb_pick
   import fmap_ram_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic       win
);

`ifdef FMAP_ARB_RR_EN
   always_comb begin
      win = REQ_LOAD;
      if (req == 2'b11) begin
         win = ~last_served;
      end else if (req[1]) begin
         win = REQ_CONV;
      end
   end
`else
   logic unused_last_served;
   assign unused_last_served = last_served;

   always_comb begin
      win = REQ_LOAD;
      if (req[1] && !req[0]) begin
         win = REQ_CONV;
      end
   end
`endif

endmodule

// File: rtl/fmap_ram_arbiter.sv
// Burst arbiter sharing one feature-map RAM port between loader and fetcher.
// FMAP_ARB_RR_EN (in fmap_arb_pick) enables round-robin on contention.
module fmap_ram_arbiter
   import fmap_ram_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int ADDR_BIT  = 10,
   parameter int MAX_BURST = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_BIT-1:0] m0_addr,
   input  logic [WIDTH-1:0]    m0_wdata,
   input  logic                m0_last,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_BIT-1:0] m1_addr,
   input  logic [WIDTH-1:0]    m1_wdata,
   input  logic                m1_last,
   output logic                m0_gnt,
   output logic                m1_gnt,
   output logic                m0_rvalid,
   output logic                m1_rvalid,
   output logic [WIDTH-1:0]    m_rdata,
   output logic                ram_en,
   output logic                ram_we,
   output logic [ADDR_BIT-1:0] ram_addr,
   output logic [WIDTH-1:0]    ram_di,
   input  logic [WIDTH-1:0]    ram_dout
);

   localparam int CNT_W = cnt_width(MAX_BURST);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             last_served_q, last_served_d;
   logic             rv0_q, rv0_d;
   logic             rv1_q, rv1_d;

   logic                win;
   logic                sel;
   logic                own;
   logic                acc;
   logic                s_req;
   logic                s_we;
   logic                s_last;
   logic [ADDR_BIT-1:0] s_addr;
   logic [WIDTH-1:0]    s_wdata;

   fmap_arb_pick u_pick (
      .req         ({m1_req, m0_req}),
      .last_served (last_served_q),
      .win         (win)
   );

   always_comb begin
      own = 1'b0;
      sel = REQ_LOAD;
      unique case (state_q)
         IDLE: begin
            own = m0_req | m1_req;
            sel = win;
         end
         OWN0: begin
            own = 1'b1;
            sel = REQ_LOAD;
         end
         OWN1: begin
            own = 1'b1;
            sel = REQ_CONV;
         end
         default: begin
            own = 1'b0;
            sel = REQ_LOAD;
         end
      endcase
   end

   assign s_req   = sel ? m1_req   : m0_req;
   assign s_we    = sel ? m1_we    : m0_we;
   assign s_last  = sel ? m1_last  : m0_last;
   assign s_addr  = sel ? m1_addr  : m0_addr;
   assign s_wdata = sel ? m1_wdata : m0_wdata;

   assign acc    = own & s_req;
   assign m0_gnt = own & ~sel;
   assign m1_gnt = own & sel;

   assign ram_en   = acc;
   assign ram_we   = acc & s_we;
   assign ram_addr = acc ? s_addr : '0;
   assign ram_di   = acc ? s_wdata : '0;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_served_d = last_served_q;
      cnt_inc       = cnt_q + 1'b1;
      rv0_d         = acc & ~s_we & ~sel;
      rv1_d         = acc & ~s_we & sel;
      // An owner with no request keeps the port; only accepted beats count.
      if (acc) begin
         if (s_last || cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d       = IDLE;
            cnt_d         = '0;
            last_served_d = sel;
         end else begin
            state_d = sel ? OWN1 : OWN0;
            cnt_d   = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         last_served_q <= 1'b1;
         rv0_q         <= 1'b0;
         rv1_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_served_q <= last_served_d;
         rv0_q         <= rv0_d;
         rv1_q         <= rv1_d;
      end
   end

   assign m0_rvalid = rv0_q;
   assign m1_rvalid = rv1_q;
   assign m_rdata   = ram_dout;

endmodule

// File: tb/tb_fmap_ram_arbiter.sv
// Directed bench for fmap_ram_arbiter with a read-first RAM model.
// Contention expectations follow FMAP_ARB_RR_EN when it is defined.
module tb_fmap_ram_arbiter;

   localparam int WIDTH = 4;
   localparam int ADDR_BIT = 10;
   localparam int MAX_BURST = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                m0_req, m0_we, m0_last;
   logic [ADDR_BIT-1:0] m0_addr;
   logic [WIDTH-1:0]    m0_wdata;
   logic                m1_req, m1_we, m1_last;
   logic [ADDR_BIT-1:0] m1_addr;
   logic [WIDTH-1:0]    m1_wdata;
   logic                m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [WIDTH-1:0]    m_rdata;
   logic                ram_en, ram_we;
   logic [ADDR_BIT-1:0] ram_addr;
   logic [WIDTH-1:0]    ram_di;
   logic [WIDTH-1:0]    ram_dout = '0;

   logic [WIDTH-1:0] mem [0:(1<<ADDR_BIT)-1];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_di;
         ram_dout <= mem[ram_addr];
      end
   end

   fmap_ram_arbiter #(
      .WIDTH     (WIDTH),
      .ADDR_BIT  (ADDR_BIT),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_last   (m0_last),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_last   (m1_last),
      .m0_gnt    (m0_gnt),
      .m1_gnt    (m1_gnt),
      .m0_rvalid (m0_rvalid),
      .m1_rvalid (m1_rvalid),
      .m_rdata   (m_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_dout  (ram_dout)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_m0(input logic r, input logic w, input int a,
                         input int d, input logic l);
      m0_req = r; m0_we = w; m0_last = l;
      m0_addr = ADDR_BIT'(a); m0_wdata = WIDTH'(d);
   endtask

   task automatic set_m1(input logic r, input logic w, input int a,
                         input int d, input logic l);
      m1_req = r; m1_we = w; m1_last = l;
      m1_addr = ADDR_BIT'(a); m1_wdata = WIDTH'(d);
   endtask

   task automatic clr();
      set_m0(0, 0, 0, 0, 0);
      set_m1(0, 0, 0, 0, 0);
   endtask

   initial begin
      logic exp1;
      clr();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt0", m0_gnt, 0);
      chk("rst_en", ram_en, 0);
      chk("rst_rv0", m0_rvalid, 0);
      chk("rst_rv1", m1_rvalid, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // write burst addr 0..3 = 1..4
      for (int i = 0; i < 4; i++) begin
         set_m0(1, 1, i, i + 1, i == 3);
         #1;
         chk("wr_gnt0", m0_gnt, 1);
         chk("wr_gnt1", m1_gnt, 0);
         chk("wr_we", ram_we, 1);
         chk("wr_addr", ram_addr, i);
         chk("wr_di", ram_di, i + 1);
         @(negedge clk);
      end
      clr();
      #1;
      chk("wr_idle_en", ram_en, 0);
      chk("wr_idle_addr", ram_addr, 0);
      @(negedge clk);

      set_m1(1, 0, 2, 0, 1);
      #1;
      chk("rd_gnt1", m1_gnt, 1);
      chk("rd_we", ram_we, 0);
      chk("rd_addr", ram_addr, 2);
      chk("rd_rv_early", m1_rvalid, 0);
      @(negedge clk);
      clr();
      #1;
      chk("rd_rv1", m1_rvalid, 1);
      chk("rd_rv0", m0_rvalid, 0);
      chk("rd_data", m_rdata, 3);
      @(negedge clk);
      #1;
      chk("rd_rv1_once", m1_rvalid, 0);

      // write then read addr 5 inside one burst
      set_m0(1, 1, 5, 7, 0);
      #1;
      chk("mix_gnt_w", m0_gnt, 1);
      @(negedge clk);
      set_m0(1, 0, 5, 0, 1);
      #1;
      chk("mix_gnt_r", m0_gnt, 1);
      chk("mix_we", ram_we, 0);
      chk("mix_wr_norv", m0_rvalid, 0);
      @(negedge clk);
      clr();
      #1;
      chk("mix_rv0", m0_rvalid, 1);
      chk("mix_data", m_rdata, 7);
      @(negedge clk);

      // contention from reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_m0(1, 0, 0, 0, 1);
         set_m1(1, 0, 0, 0, 1);
`ifdef FMAP_ARB_RR_EN
         exp1 = (k % 2) == 1;
`else
         exp1 = 1'b0;
`endif
         #1;
         chk("cont_gnt0", m0_gnt, !exp1);
         chk("cont_gnt1", m1_gnt, exp1);
         @(negedge clk);
      end
      clr();
      @(negedge clk);

      // forced release after MAX_BURST beats, m0 waiting
      for (int k = 0; k < MAX_BURST; k++) begin
         set_m1(1, 0, k, 0, 0);
         if (k >= 1) set_m0(1, 1, 200, 9, 1);
         #1;
         chk("fr_gnt1", m1_gnt, 1);
         chk("fr_gnt0", m0_gnt, 0);
         if (k >= 1) chk("fr_rv1", m1_rvalid, 1);
         @(negedge clk);
      end
      #1;
      chk("fr_hand_gnt0", m0_gnt, 1);
      chk("fr_hand_gnt1", m1_gnt, 0);
      chk("fr_hand_we", ram_we, 1);
      chk("fr_last_rv1", m1_rvalid, 1);
      @(negedge clk);
      clr();
      #1;
      chk("fr_done_en", ram_en, 0);
      @(negedge clk);

      // ownership hold while m0 pauses
      for (int i = 0; i < 2; i++) begin
         set_m0(1, 1, 300 + i, i, 0);
         #1;
         chk("hold_gnt0", m0_gnt, 1);
         @(negedge clk);
      end
      set_m0(0, 0, 0, 0, 0);
      set_m1(1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_gnt1", m1_gnt, 0);
         chk("hold_en", ram_en, 0);
         @(negedge clk);
      end
      for (int i = 2; i < MAX_BURST; i++) begin
         set_m0(1, 1, 300 + i, i, 0);
         #1;
         chk("hold_res_gnt0", m0_gnt, 1);
         chk("hold_res_gnt1", m1_gnt, 0);
         @(negedge clk);
      end
      set_m0(0, 0, 0, 0, 0);
      #1;
      chk("hold_rel_gnt1", m1_gnt, 1);
      @(negedge clk);
      clr();
      @(negedge clk);

      // reset right after an accepted read
      set_m0(1, 0, 2, 0, 0);
      #1;
      chk("mr_gnt0", m0_gnt, 1);
      @(negedge clk);
      clr();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mr_rv0", m0_rvalid, 0);
      chk("mr_en", ram_en, 0);
      set_m1(1, 0, 0, 0, 1);
      #1;
      chk("mr_idle_gnt1", m1_gnt, 1);
      @(negedge clk);
      clr();
      #1;
      chk("mr_excl", m0_rvalid & m1_rvalid, 0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
